mux4_rr_arbiter: RTL and testbench

MUX4_RR_ARBITER -- requirements
Module: mux4_rr_arbiter

---
 rtl/mux4_rr_arbiter_pkg.sv | 10 +
 rtl/mux4_rr_arbiter_if.sv | 28 ++
 rtl/mux4_rr_arbiter_mux4to1.sv | 25 ++
 rtl/mux4_rr_arbiter.sv | 87 ++++++++
 tb/tb_mux4_rr_arbiter.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/mux4_rr_arbiter_pkg.sv
// Shared constants and FSM state encoding for the 4-requester round-robin arbiter.
package mux4_rr_arbiter_pkg;
  localparam int unsigned NREQ  = 4;
  localparam int unsigned SEL_W = 2;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_VALID = 1'b1
  } state_t;
endpackage

// File: rtl/mux4_rr_arbiter_if.sv
// Requester/consumer bundle of the round-robin arbiter; master = requesters and sink, slave = arbiter.
interface mux4_rr_arbiter_if #(
  parameter int unsigned WIDTH = 48
);
  import mux4_rr_arbiter_pkg::*;

  logic [NREQ-1:0]  req;
  logic [WIDTH-1:0] din0;
  logic [WIDTH-1:0] din1;
  logic [WIDTH-1:0] din2;
  logic [WIDTH-1:0] din3;
  logic [NREQ-1:0]  gnt;
  logic [SEL_W-1:0] sel;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic             dout_ready;
  logic             busy;

  modport master (
    output req, din0, din1, din2, din3, dout_ready,
    input  gnt, sel, dout, dout_valid, busy
  );

  modport slave (
    input  req, din0, din1, din2, din3, dout_ready,
    output gnt, sel, dout, dout_valid, busy
  );
endinterface

// File: rtl/mux4_rr_arbiter_mux4to1.sv
// Plain 4:1 data multiplexer shared by all requesters.
module mux4to1
  import mux4_rr_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH = 48
) (
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [WIDTH-1:0] in3,
  input  logic [SEL_W-1:0] sel,
  output logic [WIDTH-1:0] out
);

  always_comb begin
    out = in0;
    case (sel)
      2'd0: out = in0;
      2'd1: out = in1;
      2'd2: out = in2;
      2'd3: out = in3;
    endcase
  end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter over four requesters feeding a one-word output register
// with valid/ready handoff; accept and capture may coincide for 1 word/cycle.
module mux4_rr_arbiter
  import mux4_rr_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH = 48
) (
  input logic              CLK,
  input logic              RST,
  mux4_rr_arbiter_if.slave bus
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [SEL_W-1:0] r_ptr;
  logic [SEL_W-1:0] r_last;
  logic [WIDTH-1:0] r_dout;
  logic [WIDTH-1:0] w_mux_dout;
  logic [SEL_W-1:0] w_win;
  logic [SEL_W-1:0] w_sel;
  logic [NREQ-1:0]  w_gnt;
  logic             w_any;
  logic             w_cap;

  // First set request after ptr in rotating order; ptr itself is searched last.
  function automatic logic [SEL_W-1:0] find_winner(input logic [NREQ-1:0]  req_v,
                                                   input logic [SEL_W-1:0] ptr_v);
    logic [SEL_W-1:0] idx;
    find_winner = ptr_v;
    for (int k = NREQ; k >= 1; k--) begin
      idx = ptr_v + SEL_W'(k);
      if (req_v[idx]) find_winner = idx;
    end
  endfunction

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Capture is suppressed while RST is high so no grant escapes during reset.
  always_comb begin
    w_state_nxt = r_state;
    w_gnt       = '0;
    w_any       = |bus.req;
    w_win       = find_winner(bus.req, r_ptr);
    w_cap       = w_any && ((r_state == ST_IDLE) || bus.dout_ready) && !RST;
    if (w_cap) begin
      w_gnt       = NREQ'(1) << w_win;
      w_state_nxt = ST_VALID;
    end else if ((r_state == ST_VALID) && bus.dout_ready) begin
      w_state_nxt = ST_IDLE;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_dout <= '0;
      r_ptr  <= SEL_W'(NREQ - 1);
      r_last <= '0;
    end else if (w_cap) begin
      r_dout <= w_mux_dout;
      r_ptr  <= w_win;
      r_last <= w_win;
    end
  end

  assign w_sel = w_any ? w_win : r_last;

  mux4to1 #(
    .WIDTH(WIDTH)
  ) u_mux (
    .in0(bus.din0),
    .in1(bus.din1),
    .in2(bus.din2),
    .in3(bus.din3),
    .sel(w_sel),
    .out(w_mux_dout)
  );

  assign bus.gnt        = w_gnt;
  assign bus.sel        = w_sel;
  assign bus.dout       = r_dout;
  assign bus.dout_valid = (r_state == ST_VALID);
  assign bus.busy       = (r_state == ST_VALID) || w_any;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed and randomized checks of mux4_rr_arbiter against a rotating-priority reference model.
module tb_mux4_rr_arbiter;

  localparam int unsigned W = 48;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  logic [W-1:0] din [4];
  logic [3:0]   last_gnt;

  // Reference model state
  bit           m_valid;
  logic [W-1:0] m_dout;
  int           m_ptr;
  int           m_last;
  int           wait_caps [4];

  mux4_rr_arbiter_if #(.WIDTH(W)) bus ();

  mux4_rr_arbiter #(.WIDTH(W)) dut (
    .CLK(clk),
    .RST(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int model_winner(input logic [3:0] r);
    for (int k = 1; k <= 4; k++) begin
      int c;
      c = (m_ptr + k) % 4;
      if (r[c]) return c;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_valid = 1'b0;
    m_dout  = '0;
    m_ptr   = 3;
    m_last  = 0;
    for (int i = 0; i < 4; i++) wait_caps[i] = 0;
  endtask

  task automatic drive(input logic [3:0] r, input logic rdy);
    bus.req        = r;
    bus.dout_ready = rdy;
    bus.din0       = din[0];
    bus.din1       = din[1];
    bus.din2       = din[2];
    bus.din3       = din[3];
  endtask

  // Called at posedge+1 with inputs driven: checks combinational outputs, clocks, checks registers.
  task automatic step();
    int   win;
    bit   cap;
    logic [3:0] egnt;
    #3;
    win  = model_winner(bus.req);
    cap  = (win >= 0) && (!m_valid || bus.dout_ready);
    egnt = cap ? (4'b0001 << win) : 4'b0000;
    last_gnt = bus.gnt;
    check("gnt", 64'(bus.gnt), 64'(egnt));
    check("sel", 64'(bus.sel), 64'((win >= 0) ? win : m_last));
    check("busy", 64'(bus.busy), 64'(m_valid || (bus.req != 4'b0)));
    // Fairness from the DUT's own grants: a held request waits at most 3 other captures.
    if (bus.gnt != 4'b0) begin
      for (int i = 0; i < 4; i++) begin
        if (!bus.req[i] || bus.gnt[i]) wait_caps[i] = 0;
        else begin
          wait_caps[i]++;
          check("fair_wait", 64'(wait_caps[i] <= 3), 64'(1));
        end
      end
    end else begin
      for (int i = 0; i < 4; i++) if (!bus.req[i]) wait_caps[i] = 0;
    end
    @(posedge clk);
    if (cap) begin
      m_dout  = din[win];
      m_ptr   = win;
      m_last  = win;
      m_valid = 1'b1;
    end else if (m_valid && bus.dout_ready) begin
      m_valid = 1'b0;
    end
    #1;
    check("dout_valid", 64'(bus.dout_valid), 64'(m_valid));
    check("dout", 64'(bus.dout), 64'(m_dout));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_reset();
    check("rst_gnt", 64'(bus.gnt), 64'(0));
    check("rst_valid", 64'(bus.dout_valid), 64'(0));
    check("rst_dout", 64'(bus.dout), 64'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    logic [3:0] exp_gnt_seq [5];
    logic [W-1:0] exp_dout_seq [5];
    logic [3:0] r;
    n_vec = 0;
    n_err = 0;
    rst   = 1'b1;
    for (int i = 0; i < 4; i++) din[i] = W'(48'hAAAA_0000 + i);
    din[0] = W'(1);
    drive(4'b1111, 1'b0);
    model_reset();

    // Reset with all requests active: no grant, empty output, sel points at requester 0
    #2;
    check("rst_gnt", 64'(bus.gnt), 64'(0));
    check("rst_valid", 64'(bus.dout_valid), 64'(0));
    check("rst_dout", 64'(bus.dout), 64'(0));
    check("rst_sel", 64'(bus.sel), 64'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    step();
    check("first_cap_dout", 64'(bus.dout), 64'(1));
    check("first_cap_valid", 64'(bus.dout_valid), 64'(1));

    // Rotation
    do_reset();
    for (int i = 0; i < 4; i++) din[i] = W'(i + 10);
    exp_gnt_seq  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    exp_dout_seq = '{W'(10), W'(11), W'(12), W'(13), W'(10)};
    drive(4'b1111, 1'b1);
    for (int s = 0; s < 5; s++) begin
      step();
      check("rot_gnt", 64'(last_gnt), 64'(exp_gnt_seq[s]));
      check("rot_dout", 64'(bus.dout), 64'(exp_dout_seq[s]));
    end

    // Backpressure
    drive(4'b0100, 1'b0);
    for (int s = 0; s < 5; s++) begin
      step();
      check("bp_gnt", 64'(last_gnt), 64'(0));
      check("bp_dout", 64'(bus.dout), 64'(10));
    end
    drive(4'b0100, 1'b1);
    step();
    check("bp_release_gnt", 64'(last_gnt), 64'(4'b0100));
    check("bp_release_dout", 64'(bus.dout), 64'(12));

    // Skip over idle requesters from ptr=0
    do_reset();
    drive(4'b0001, 1'b1);
    step();
    drive(4'b1001, 1'b1);
    step();
    check("skip_gnt3", 64'(last_gnt), 64'(4'b1000));
    check("skip_dout3", 64'(bus.dout), 64'(13));
    step();
    check("skip_gnt0", 64'(last_gnt), 64'(4'b0001));

    // Drain
    drive(4'b0000, 1'b1);
    step();
    check("drain_valid", 64'(bus.dout_valid), 64'(0));
    check("drain_busy", 64'(bus.busy), 64'(0));

    // Asynchronous reset between edges while a word is held
    drive(4'b0001, 1'b0);
    step();
    drive(4'b0110, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check("async_rst_valid", 64'(bus.dout_valid), 64'(0));
    check("async_rst_gnt", 64'(bus.gnt), 64'(0));
    check("async_rst_dout", 64'(bus.dout), 64'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    step();
    check("post_rst_gnt", 64'(last_gnt), 64'(4'b0010));
    check("post_rst_dout", 64'(bus.dout), 64'(11));

    // Randomized traffic with sticky requests
    r = 4'b0000;
    for (int s = 0; s < 400; s++) begin
      for (int i = 0; i < 4; i++) begin
        din[i] = W'({$urandom, $urandom});
        if ($urandom_range(0, 3) == 0) r[i] = ~r[i];
      end
      drive(r, ($urandom_range(0, 3) != 0));
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
